// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel pipeline: FSM state encoding, default pixel
// width and a counter-width helper.
package sobel_pkg;

    localparam int unsigned DefaultDataW = 8;

    // Line buffer frame-tracking states
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFill   = 2'd1,
        StStream = 2'd2
    } state_e;

    // Bits needed to hold 0 .. value-1; never less than 1
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/line_mem.sv
// Single-port read-first line memory. word_o is the stored word at addr_i
// before this cycle's write; rdata_o is that word registered on enable.
module line_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 640,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] word_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    assign word_o  = mem_q[addr_i];
    assign rdata_o = rdata_q;

    // Storage array; contents deliberately not reset
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read-first output register: old word is captured alongside the write
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/line_window_buffer.sv
// Vertical-window line buffer: stores KERNEL_H-1 image lines and presents, per
// accepted pixel, the column of KERNEL_H pixels ending at that pixel.
module line_window_buffer
    import sobel_pkg::*;
#(
    parameter int unsigned DATA_W   = DefaultDataW,
    parameter int unsigned IMG_W    = 640,
    parameter int unsigned IMG_H    = 480,
    parameter int unsigned KERNEL_H = 3
) (
    input  logic                         sys_clk_i,
    input  logic                         sys_rst_i,
    input  logic [DATA_W-1:0]            pix_i,
    input  logic                         pix_vld_i,
    input  logic                         sof_i,
    output logic [KERNEL_H*DATA_W-1:0]   col_o,
    output logic                         col_vld_o,
    output logic [clog2_min1(IMG_W)-1:0] col_x_o,
    output logic [clog2_min1(IMG_H)-1:0] row_y_o,
    output logic                         frame_done_o
);

    localparam int unsigned XW = clog2_min1(IMG_W);
    localparam int unsigned YW = clog2_min1(IMG_H);
    localparam int unsigned NL = KERNEL_H - 1;

    localparam logic [XW-1:0] XLast   = XW'(IMG_W - 1);
    localparam logic [YW-1:0] YLast   = YW'(IMG_H - 1);
    localparam logic [YW-1:0] YFilled = YW'(KERNEL_H - 1);

    state_e            state_q, state_d;
    logic [XW-1:0]     x_q, x_d, cur_x;
    logic [YW-1:0]     y_q, y_d, cur_y;
    logic              restart, accept, last_pix, fill_done;
    logic              col_vld_d, frame_done_d;
    logic              col_vld_q, frame_done_q;
    logic [DATA_W-1:0] pix_q;
    logic [XW-1:0]     col_x_q;
    logic [YW-1:0]     row_y_q;

    logic [DATA_W-1:0] word  [NL];
    logic [DATA_W-1:0] rdata [NL];

    // sof_i forces the accepted pixel to (0,0) regardless of state
    assign restart   = pix_vld_i && sof_i;
    assign accept    = pix_vld_i && (sof_i || (state_q != StIdle));
    assign cur_x     = restart ? '0 : x_q;
    assign cur_y     = restart ? '0 : y_q;
    assign last_pix  = (cur_x == XLast) && (cur_y == YLast);
    assign fill_done = (cur_x == '0) && (cur_y == YFilled);

    // Next-state logic for frame tracking
    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = StFill;
        end else if (accept) begin
            unique case (state_q)
                StFill:   if (fill_done) state_d = StStream;
                StStream: if (last_pix)  state_d = StIdle;
                default:  ;
            endcase
        end
    end

    // Raster position of the next pixel
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (accept) begin
            if (cur_x == XLast) begin
                x_d = '0;
                y_d = (cur_y == YLast) ? '0 : cur_y + YW'(1);
            end else begin
                x_d = cur_x + XW'(1);
                y_d = cur_y;
            end
        end
    end

    // Valid only once every slice holds data from the current frame
    always_comb begin
        col_vld_d    = accept && !restart &&
                       ((state_q == StStream) || ((state_q == StFill) && fill_done));
        frame_done_d = accept && !restart && (state_q == StStream) && last_pix;
    end

    // State, counters and output registers
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_q      <= StIdle;
            x_q          <= '0;
            y_q          <= '0;
            col_vld_q    <= 1'b0;
            frame_done_q <= 1'b0;
            pix_q        <= '0;
            col_x_q      <= '0;
            row_y_q      <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            col_vld_q    <= col_vld_d;
            frame_done_q <= frame_done_d;
            if (accept) begin
                pix_q   <= pix_i;
                col_x_q <= cur_x;
                row_y_q <= cur_y;
            end
        end
    end

    // Line k holds row y-(k+1); each accept shifts the column down one line
    for (genvar k = 0; k < NL; k++) begin : g_line
        logic [DATA_W-1:0] wdata;
        if (k == 0) begin : g_head
            assign wdata = pix_i;
        end else begin : g_tail
            assign wdata = word[k-1];
        end

        line_mem #(
            .DATA_W (DATA_W),
            .DEPTH  (IMG_W),
            .ADDR_W (XW)
        ) u_line_mem (
            .clk_i   (sys_clk_i),
            .rst_ni  (sys_rst_i),
            .en_i    (accept),
            .addr_i  (cur_x),
            .wdata_i (wdata),
            .word_o  (word[k]),
            .rdata_o (rdata[k])
        );

        assign col_o[(k+1)*DATA_W +: DATA_W] = rdata[k];
    end

    // The oldest line has nowhere further to shift
    logic unused_tail;
    assign unused_tail = ^word[NL-1];

    assign col_o[DATA_W-1:0] = pix_q;
    assign col_vld_o         = col_vld_q;
    assign col_x_o           = col_x_q;
    assign row_y_o           = row_y_q;
    assign frame_done_o      = frame_done_q;

endmodule

// File: tb/tb_line_window_buffer.sv
// Self-checking bench for line_window_buffer with a 4x4 image and 3-row window.
module tb_line_window_buffer;

    localparam int unsigned DW = 8;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;
    localparam int unsigned K  = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   pix;
    logic            vld;
    logic            sof;
    logic [K*DW-1:0] col;
    logic            col_vld;
    logic [1:0]      cx;
    logic [1:0]      ry;
    logic            done;

    line_window_buffer #(
        .DATA_W   (DW),
        .IMG_W    (W),
        .IMG_H    (H),
        .KERNEL_H (K)
    ) dut (
        .sys_clk_i    (clk),
        .sys_rst_i    (rst_n),
        .pix_i        (pix),
        .pix_vld_i    (vld),
        .sof_i        (sof),
        .col_o        (col),
        .col_vld_o    (col_vld),
        .col_x_o      (cx),
        .row_y_o      (ry),
        .frame_done_o (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the current frame as a 2-D image
    logic [DW-1:0] img [H][W];
    bit            m_active;
    int            m_x, m_y;
    int            e_x, e_y;
    bit            e_vld, e_done;
    logic [DW-1:0] e_s [K];
    int            acc_cnt = 0;
    int            done_seen = 0;
    int            vld_seen = 0;
    int            last_done_acc = -1;
    int            done_gap = 0;

    typedef struct {
        bit            sof;
        logic [DW-1:0] pix;
        bit            e_vld;
        bit            e_done;
        logic [DW-1:0] e_s [K];
        int            ex;
        int            ey;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [DW-1:0] pv(input int x, input int y);
        return DW'(16 * y + x);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_x = 0;
        m_y = 0;
        e_x = 0;
        e_y = 0;
        e_vld = 1'b0;
        e_done = 1'b0;
    endtask

    task automatic model_accept(input bit v, input bit s, input logic [DW-1:0] p);
        e_vld = 1'b0;
        e_done = 1'b0;
        if (v && (s || m_active)) begin
            if (s) begin
                m_x = 0;
                m_y = 0;
                m_active = 1'b1;
            end
            img[m_y][m_x] = p;
            e_x = m_x;
            e_y = m_y;
            if (m_y >= int'(K) - 1) begin
                e_vld = 1'b1;
                for (int k = 0; k < int'(K); k++) e_s[k] = img[m_y-k][m_x];
            end
            if (m_x == int'(W) - 1 && m_y == int'(H) - 1) begin
                e_done = 1'b1;
                m_active = 1'b0;
            end
            acc_cnt++;
            m_x++;
            if (m_x == int'(W)) begin
                m_x = 0;
                m_y = (m_y == int'(H) - 1) ? 0 : m_y + 1;
            end
        end
    endtask

    task automatic observe();
        if (col_vld === 1'b1) vld_seen++;
        if (done === 1'b1) begin
            if (last_done_acc >= 0) done_gap = acc_cnt - last_done_acc;
            last_done_acc = acc_cnt;
            done_seen++;
        end
    endtask

    task automatic step(input bit v, input bit s, input logic [DW-1:0] p);
        vld = v;
        sof = s;
        pix = p;
        @(posedge clk);
        model_accept(v, s, p);
        #1;
        chk("col_vld", 64'(col_vld), 64'(e_vld));
        chk("frame_done", 64'(done), 64'(e_done));
        chk("col_x", 64'(cx), 64'(e_x));
        chk("row_y", 64'(ry), 64'(e_y));
        if (e_vld) begin
            for (int k = 0; k < int'(K); k++)
                chk($sformatf("slice%0d", k), 64'(col[k*DW +: DW]), 64'(e_s[k]));
        end
        observe();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, DW'($urandom));
    endtask

    task automatic frame(input int npix, input bit gaps);
        for (int i = 0; i < npix; i++) begin
            if (gaps) idle(int'($urandom_range(1, 3)));
            step(1'b1, i == 0, pv(i % int'(W), i / int'(W)));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_col"}, 64'(col), 64'd0);
        chk({tag, "_col_vld"}, 64'(col_vld), 64'd0);
        chk({tag, "_col_x"}, 64'(cx), 64'd0);
        chk({tag, "_row_y"}, 64'(ry), 64'd0);
        chk({tag, "_frame_done"}, 64'(done), 64'd0);
    endtask

    int d0, v0;

    initial begin
        // Expected columns for one continuous frame, from the pixel formula
        for (int i = 0; i < 16; i++) begin
            int x, y;
            x = i % int'(W);
            y = i / int'(W);
            tbl[i].sof    = (i == 0);
            tbl[i].pix    = pv(x, y);
            tbl[i].e_vld  = (y >= 2);
            tbl[i].e_done = (i == 15);
            tbl[i].e_s[0] = pv(x, y);
            tbl[i].e_s[1] = (y >= 1) ? pv(x, y - 1) : '0;
            tbl[i].e_s[2] = (y >= 2) ? pv(x, y - 2) : '0;
            tbl[i].ex     = x;
            tbl[i].ey     = y;
        end

        // Reset values, then sof-less pixels are dropped
        rst_n = 1'b0;
        vld = 1'b0;
        sof = 1'b0;
        pix = '0;
        #12;
        chk_all_zero("reset");
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, pv(i % 4, i / 4));

        // Continuous frame checked against the table
        v0 = vld_seen;
        d0 = done_seen;
        for (int i = 0; i < 16; i++) begin
            vld = 1'b1;
            sof = tbl[i].sof;
            pix = tbl[i].pix;
            @(posedge clk);
            model_accept(1'b1, tbl[i].sof, tbl[i].pix);
            #1;
            chk($sformatf("tbl%0d_vld", i), 64'(col_vld), 64'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_done", i), 64'(done), 64'(tbl[i].e_done));
            chk($sformatf("tbl%0d_x", i), 64'(cx), 64'(tbl[i].ex));
            chk($sformatf("tbl%0d_y", i), 64'(ry), 64'(tbl[i].ey));
            if (tbl[i].e_vld) begin
                for (int k = 0; k < int'(K); k++)
                    chk($sformatf("tbl%0d_slice%0d", i, k), 64'(col[k*DW +: DW]),
                        64'(tbl[i].e_s[k]));
            end
            observe();
        end
        vld = 1'b0;
        sof = 1'b0;
        chk("tbl_valid_count", 64'(vld_seen - v0), 64'd8);
        chk("tbl_done_count", 64'(done_seen - d0), 64'd1);
        // Outputs hold with no accepted pixel
        idle(2);
        chk("hold_slice0", 64'(col[DW-1:0]), 64'h33);
        chk("hold_slice2", 64'(col[2*DW +: DW]), 64'h13);

        // Same frame with random gaps
        v0 = vld_seen;
        d0 = done_seen;
        frame(16, 1'b1);
        chk("gap_valid_count", 64'(vld_seen - v0), 64'd8);
        chk("gap_done_count", 64'(done_seen - d0), 64'd1);

        // Abort at pixel (1,2) with a new sof
        d0 = done_seen;
        frame(9, 1'b0);
        frame(16, 1'b0);
        chk("abort_done_count", 64'(done_seen - d0), 64'd1);

        // Asynchronous reset mid-frame just before pixel (2,3)
        d0 = done_seen;
        frame(14, 1'b0);
        vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 1'b0, pv(2, 3));
        step(1'b1, 1'b0, pv(3, 3));
        chk("reset_no_done", 64'(done_seen - d0), 64'd0);
        frame(16, 1'b0);
        chk("post_reset_done", 64'(done_seen - d0), 64'd1);

        // Two frames back-to-back
        d0 = done_seen;
        last_done_acc = -1;
        frame(16, 1'b0);
        frame(16, 1'b0);
        chk("b2b_done_count", 64'(done_seen - d0), 64'd2);
        chk("b2b_done_gap", 64'(done_gap), 64'd16);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit v, s;
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 39) == 0);
            step(v, s, DW'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
